// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arbiter_pkg;

  localparam int unsigned data_width  = 32;
  localparam int unsigned addr_width  = 8;
  localparam int unsigned mask_width  = data_width / 8;
  localparam int unsigned baddr_width = addr_width + 2;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FRESH = 2'd1,
    HELD  = 2'd2
  } slot_state_e;

  typedef struct packed {
    logic                  en;
    logic                  wen;
    logic [mask_width-1:0] wmask;
    logic [addr_width-1:0] addr;
    logic [data_width-1:0] din;
  } sram_cmd_t;

endpackage

// File: rtl/sram_arb_resp_slot.sv
// One-deep response slot: presents sram_dout directly in the cycle after issue,
// then falls back to a hold register while the consumer stalls.
module sram_arb_resp_slot
  import sram_arbiter_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue,
  input  logic                  is_write,
  input  logic [data_width-1:0] sram_dout,
  input  logic                  resp_ready,
  output logic                  resp_valid,
  output logic [data_width-1:0] resp_data,
  output logic                  free
);

  slot_state_e           state_q;
  slot_state_e           state_d;
  logic                  write_q;
  logic [data_width-1:0] hold_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      write_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (issue) write_q <= is_write;
      // Capture the one-cycle SRAM output before another access overwrites it.
      if (state_q == FRESH && !resp_ready) hold_q <= write_q ? '0 : sram_dout;
    end
  end

  always_comb begin
    state_d = state_q;
    if (issue) begin
      state_d = FRESH;
    end else begin
      unique case (state_q)
        EMPTY:       state_d = EMPTY;
        FRESH, HELD: state_d = resp_ready ? EMPTY : HELD;
        default:     state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    resp_valid = (state_q != EMPTY);
    free       = !resp_valid || resp_ready;
    resp_data  = '0;
    unique case (state_q)
      FRESH:   resp_data = write_q ? '0 : sram_dout;
      HELD:    resp_data = hold_q;
      default: resp_data = '0;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin sharing of one 1R1W SRAM between an instruction-fetch port and a data port.
module sram_arbiter
  import sram_arbiter_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_req_valid,
  output logic                   i_req_ready,
  input  logic [baddr_width-1:0] i_req_addr,
  output logic                   i_resp_valid,
  input  logic                   i_resp_ready,
  output logic [data_width-1:0]  i_resp_data,
  input  logic                   d_req_valid,
  output logic                   d_req_ready,
  input  logic [baddr_width-1:0] d_req_addr,
  input  logic                   d_req_wen,
  input  logic [mask_width-1:0]  d_req_wmask,
  input  logic [data_width-1:0]  d_req_wdata,
  output logic                   d_resp_valid,
  input  logic                   d_resp_ready,
  output logic [data_width-1:0]  d_resp_data,
  output logic                   sram_en,
  output logic                   sram_wen,
  output logic [mask_width-1:0]  sram_wmask,
  output logic [addr_width-1:0]  sram_addr,
  output logic [data_width-1:0]  sram_din,
  input  logic [data_width-1:0]  sram_dout
);

  logic      last_grant_q;
  logic      i_free;
  logic      d_free;
  logic      elig_i;
  logic      elig_d;
  logic      grant_i;
  logic      grant_d;
  sram_cmd_t cmd;

  // Word addressing drops the byte-offset bits.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_req_addr[1:0], d_req_addr[1:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= PORT_D;
    end else if (grant_i) begin
      last_grant_q <= PORT_I;
    end else if (grant_d) begin
      last_grant_q <= PORT_D;
    end
  end

  // On a tie the port that did not win last time is granted.
  always_comb begin
    elig_i  = i_req_valid && i_free && !reset;
    elig_d  = d_req_valid && d_free && !reset;
    grant_i = elig_i && (!elig_d || (last_grant_q == PORT_D));
    grant_d = elig_d && (!elig_i || (last_grant_q == PORT_I));
  end

  always_comb begin
    cmd = '0;
    if (grant_d) begin
      cmd.en   = 1'b1;
      cmd.wen  = d_req_wen;
      cmd.addr = d_req_addr[addr_width+1:2];
      if (d_req_wen) begin
        cmd.wmask = d_req_wmask;
        cmd.din   = d_req_wdata;
      end
    end else if (grant_i) begin
      cmd.en   = 1'b1;
      cmd.addr = i_req_addr[addr_width+1:2];
    end
  end

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;
  assign sram_en     = cmd.en;
  assign sram_wen    = cmd.wen;
  assign sram_wmask  = cmd.wmask;
  assign sram_addr   = cmd.addr;
  assign sram_din    = cmd.din;

  sram_arb_resp_slot u_i_slot (
    .clock      (clock),
    .reset      (reset),
    .issue      (grant_i),
    .is_write   (1'b0),
    .sram_dout  (sram_dout),
    .resp_ready (i_resp_ready),
    .resp_valid (i_resp_valid),
    .resp_data  (i_resp_data),
    .free       (i_free)
  );

  sram_arb_resp_slot u_d_slot (
    .clock      (clock),
    .reset      (reset),
    .issue      (grant_d),
    .is_write   (d_req_wen),
    .sram_dout  (sram_dout),
    .resp_ready (d_resp_ready),
    .resp_valid (d_resp_valid),
    .resp_data  (d_resp_data),
    .free       (d_free)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, reference memory and per-port response scoreboards.
module tb_sram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req_valid, i_req_ready, i_resp_valid, i_resp_ready;
  logic [9:0]  i_req_addr;
  logic [31:0] i_resp_data;
  logic        d_req_valid, d_req_ready, d_req_wen, d_resp_valid, d_resp_ready;
  logic [9:0]  d_req_addr;
  logic [3:0]  d_req_wmask;
  logic [31:0] d_req_wdata, d_resp_data;
  logic        sram_en, sram_wen;
  logic [3:0]  sram_wmask;
  logic [7:0]  sram_addr;
  logic [31:0] sram_din, sram_dout;

  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];

  logic [31:0] i_q[$];
  logic [31:0] d_q[$];
  logic [31:0] exp_i, exp_d;
  logic [7:0]  mon_a;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  sram_arbiter dut (
    .clock(clock), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wen(d_req_wen), .d_req_wmask(d_req_wmask), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready), .d_resp_data(d_resp_data),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // Behavioural sram_1r1w: registered read, byte-masked write, plus a backdoor preload.
  always @(posedge clock) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (sram_en) begin
      if (sram_wen) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        sram_dout <= mem[sram_addr];
      end
    end
  end

  // Scoreboard: expectations pushed at accept, popped when a response handshake completes.
  always @(negedge clock) begin
    if (reset) begin
      i_q.delete();
      d_q.delete();
    end else begin
      if (i_resp_valid && i_resp_ready) begin
        n_checks++;
        if (i_q.size() == 0) begin
          $display("FAIL i_resp_unexpected: got %h, required no response", i_resp_data);
        end else begin
          exp_i = i_q.pop_front();
          if (i_resp_data !== exp_i) $display("FAIL i_resp_data: got %h, required %h", i_resp_data, exp_i);
          else n_pass++;
        end
      end
      if (d_resp_valid && d_resp_ready) begin
        n_checks++;
        if (d_q.size() == 0) begin
          $display("FAIL d_resp_unexpected: got %h, required no response", d_resp_data);
        end else begin
          exp_d = d_q.pop_front();
          if (d_resp_data !== exp_d) $display("FAIL d_resp_data: got %h, required %h", d_resp_data, exp_d);
          else n_pass++;
        end
      end
      if (i_req_valid && i_req_ready) i_q.push_back(ref_mem[i_req_addr[9:2]]);
      if (d_req_valid && d_req_ready) begin
        mon_a = d_req_addr[9:2];
        if (d_req_wen) begin
          for (int b = 0; b < 4; b++)
            if (d_req_wmask[b]) ref_mem[mon_a][8*b +: 8] = d_req_wdata[8*b +: 8];
          d_q.push_back(32'h0);
        end else begin
          d_q.push_back(ref_mem[mon_a]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic idle_inputs();
    i_req_valid = 0; i_req_addr = '0; i_resp_ready = 1;
    d_req_valid = 0; d_req_addr = '0; d_req_wen = 0; d_req_wmask = '0; d_req_wdata = '0;
    d_resp_ready = 1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] v);
    bd_we = 1; bd_addr = a; bd_data = v;
    ref_mem[a] = v;
    step();
    bd_we = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1;
    step(); step();
    reset = 0;
  endtask

  task automatic drain(input int n);
    idle_inputs();
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    i_req_valid = 1; d_req_valid = 1;
    step();
    @(negedge clock);
    n_checks++;
    if ({i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, sram_en, sram_wen} !== 6'b0)
      $display("FAIL reset_ctrl: got %b, required 000000",
               {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, sram_en, sram_wen});
    else n_pass++;
    step();
    reset = 0; i_req_valid = 0; d_req_valid = 0;
    @(negedge clock);
    n_checks++;
    if (i_resp_data !== 32'h0 || d_resp_data !== 32'h0)
      $display("FAIL reset_data: got %h/%h, required 0/0", i_resp_data, d_resp_data);
    else n_pass++;
  endtask

  task automatic test_single_read();
    apply_reset();
    poke(8'd4, 32'hDEADBEEF);
    i_req_valid = 1; i_req_addr = 10'h010;
    @(negedge clock);
    n_checks++;
    if (!(i_req_ready === 1'b1 && sram_en === 1'b1 && sram_addr === 8'd4 && sram_wen === 1'b0))
      $display("FAIL read_issue: got ready=%b en=%b addr=%h wen=%b, required 1 1 04 0",
               i_req_ready, sram_en, sram_addr, sram_wen);
    else n_pass++;
    step();
    i_req_valid = 0;
    @(negedge clock);
    n_checks++;
    if (i_resp_valid !== 1'b1 || i_resp_data !== 32'hDEADBEEF)
      $display("FAIL read_resp: got valid=%b data=%h, required 1 deadbeef", i_resp_valid, i_resp_data);
    else n_pass++;
    drain(2);
  endtask

  task automatic test_round_robin();
    apply_reset();
    poke(8'd4, 32'h44444444);
    poke(8'd9, 32'h99999999);
    i_req_valid = 1; i_req_addr = 10'h010;
    d_req_valid = 1; d_req_addr = 10'h024;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      n_checks++;
      if (i_req_ready !== (k % 2 == 0) || d_req_ready !== (k % 2 == 1))
        $display("FAIL rr_grant[%0d]: got i=%b d=%b, required i=%b d=%b",
                 k, i_req_ready, d_req_ready, (k % 2 == 0), (k % 2 == 1));
      else n_pass++;
      step();
    end
    drain(3);
  endtask

  task automatic test_write_then_read();
    apply_reset();
    poke(8'd8, 32'hAAAAAAAA);
    d_req_valid = 1; d_req_addr = 10'h020; d_req_wen = 1;
    d_req_wmask = 4'b0011; d_req_wdata = 32'h12345678;
    @(negedge clock);
    n_checks++;
    if (!(d_req_ready === 1'b1 && sram_wen === 1'b1 && sram_wmask === 4'b0011 &&
          sram_din === 32'h12345678 && sram_addr === 8'd8))
      $display("FAIL write_issue: got rdy=%b wen=%b mask=%b din=%h addr=%h, required 1 1 0011 12345678 08",
               d_req_ready, sram_wen, sram_wmask, sram_din, sram_addr);
    else n_pass++;
    step();
    d_req_wen = 0; d_req_wmask = '0; d_req_wdata = '0;
    @(negedge clock);
    n_checks++;
    if (d_resp_valid !== 1'b1 || d_resp_data !== 32'h0 || sram_wen !== 1'b0 || sram_din !== 32'h0)
      $display("FAIL write_ack: got valid=%b data=%h wen=%b din=%h, required 1 0 0 0",
               d_resp_valid, d_resp_data, sram_wen, sram_din);
    else n_pass++;
    step();
    d_req_valid = 0;
    @(negedge clock);
    n_checks++;
    if (d_resp_valid !== 1'b1 || d_resp_data !== 32'hAAAA5678)
      $display("FAIL raw_read: got valid=%b data=%h, required 1 aaaa5678", d_resp_valid, d_resp_data);
    else n_pass++;
    drain(2);
  endtask

  task automatic test_backpressure();
    apply_reset();
    poke(8'd1, 32'h11111111);
    poke(8'd2, 32'h22222222);
    i_req_valid = 1; i_req_addr = 10'h004; i_resp_ready = 0;
    d_req_valid = 1; d_req_addr = 10'h008;
    @(negedge clock);
    n_checks++;
    if (i_req_ready !== 1'b1 || d_req_ready !== 1'b0)
      $display("FAIL bp_first_grant: got i=%b d=%b, required i=1 d=0", i_req_ready, d_req_ready);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clock);
      n_checks++;
      if (!(i_req_ready === 1'b0 && d_req_ready === 1'b1 && i_resp_valid === 1'b1 &&
            i_resp_data === 32'h11111111))
        $display("FAIL bp_hold[%0d]: got irdy=%b drdy=%b ivalid=%b idata=%h, required 0 1 1 11111111",
                 k, i_req_ready, d_req_ready, i_resp_valid, i_resp_data);
      else n_pass++;
    end
    step();
    i_resp_ready = 1;
    @(negedge clock);
    n_checks++;
    if (i_req_ready !== 1'b1 || d_req_ready !== 1'b0)
      $display("FAIL bp_release: got i=%b d=%b, required i=1 d=0", i_req_ready, d_req_ready);
    else n_pass++;
    step();
    drain(3);
  endtask

  task automatic test_reset_mid_txn();
    apply_reset();
    poke(8'd1, 32'h11111111);
    i_req_valid = 1; i_req_addr = 10'h004;
    @(negedge clock);
    n_checks++;
    if (i_req_ready !== 1'b1) $display("FAIL rst_mid_accept: got %b, required 1", i_req_ready);
    else n_pass++;
    step();
    reset = 1;
    @(negedge clock);
    n_checks++;
    if (sram_en !== 1'b0 || i_req_ready !== 1'b0)
      $display("FAIL rst_mid_gate: got en=%b rdy=%b, required 0 0", sram_en, i_req_ready);
    else n_pass++;
    step();
    reset = 0; i_req_valid = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      n_checks++;
      if (i_resp_valid !== 1'b0 || d_resp_valid !== 1'b0)
        $display("FAIL rst_mid_stale[%0d]: got i=%b d=%b, required 0 0", k, i_resp_valid, d_resp_valid);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    int accepts;
    apply_reset();
    poke(8'd2, 32'h22222222);
    accepts = 0;
    d_req_valid = 1; d_req_addr = 10'h008; d_resp_ready = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (d_req_ready === 1'b1) accepts++;
      step();
    end
    n_checks++;
    if (accepts != 1 || d_resp_valid !== 1'b1)
      $display("FAIL b2b_single_accept: got accepts=%0d valid=%b, required 1 1", accepts, d_resp_valid);
    else n_pass++;
    d_resp_ready = 1;
    @(negedge clock);
    n_checks++;
    if (d_req_ready !== 1'b1 || d_resp_data !== 32'h22222222)
      $display("FAIL b2b_regrant: got rdy=%b data=%h, required 1 22222222", d_req_ready, d_resp_data);
    else n_pass++;
    step();
    d_req_valid = 0;
    @(negedge clock);
    n_checks++;
    if (d_resp_valid !== 1'b1) $display("FAIL b2b_second_resp: got %b, required 1", d_resp_valid);
    else n_pass++;
    drain(2);
  endtask

  initial begin
    bd_we = 0; bd_addr = '0; bd_data = '0;
    idle_inputs();
    reset = 1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_then_read();
    test_backpressure();
    test_reset_mid_txn();
    test_back_to_back();
    drain(2);
    n_checks++;
    if (i_q.size() != 0 || d_q.size() != 0)
      $display("FAIL sb_drained: got i=%0d d=%0d pending, required 0 0", i_q.size(), d_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
